// File: rtl/rv_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// rv_multicycle_ctrl_if
//   Bundles every control-path signal of the multi-cycle RV32 controller:
//   the one-hot instruction-type flags from the type decoder, the branch
//   comparator result, the imem/dmem request/acknowledge handshakes, the
//   datapath strobes and selects, and the retire/trap status outputs.
//
//   master : the controller (drives requests, strobes, selects, status)
//   slave  : the surrounding datapath / memories (drive flags, acks, br_taken)
//
//   Signals
//     R, I, L, Jr, S, Sb, aui, lui, J  type flags (one-hot when legal)
//     br_taken                          branch comparator result
//     imem_ack / dmem_ack               memory data valid / access complete
//     imem_req / dmem_req / dmem_we     memory requests and store qualifier
//     ir_en, pc_en, reg_we              datapath load/write strobes
//     pc_sel[1:0], wb_sel[1:0], alu_src datapath selects
//     retire, instret[CNT_W-1:0]        retire pulse and retired count
//     trap, trap_cause[1:0]             sticky trap and its cause
// ---------------------------------------------------------------------------
interface rv_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             R, I, L, Jr, S, Sb, aui, lui, J;
  logic             br_taken;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_en;
  logic             pc_en;
  logic [1:0]       pc_sel;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic             alu_src;
  logic             retire;
  logic [CNT_W-1:0] instret;
  logic             trap;
  logic [1:0]       trap_cause;

  modport master (
    input  R, I, L, Jr, S, Sb, aui, lui, J,
    input  br_taken, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_en, pc_en, pc_sel,
    output reg_we, wb_sel, alu_src, retire, instret, trap, trap_cause
  );

  modport slave (
    output R, I, L, Jr, S, Sb, aui, lui, J,
    output br_taken, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_en, pc_en, pc_sel,
    input  reg_we, wb_sel, alu_src, retire, instret, trap, trap_cause
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// rv_multicycle_ctrl
//   Multi-cycle control FSM for the RV32 core. Sequences FETCH, DECODE,
//   EXEC, MEM and WB, latching the instruction-type flags in DECODE and
//   decoding all datapath controls from the state and that latched class.
//   A wait-state watchdog traps on stalled imem/dmem handshakes.
//
//   Parameters
//     TIMEOUT  max wait cycles with a request high and no ack (0 = off)
//     CNT_W    width of the retired-instruction counter
//   Ports
//     clk      rising-edge clock
//     rst      synchronous, active-low reset
//     bus      controller side (master) of rv_multicycle_ctrl_if
// ---------------------------------------------------------------------------
module rv_multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  rv_multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  // Bit positions of each type inside the latched class vector.
  localparam int C_R = 0, C_I = 1, C_L = 2, C_JR = 3, C_S = 4;
  localparam int C_SB = 5, C_AUI = 6, C_LUI = 7, C_J = 8;

  // Wide enough to hold TIMEOUT-1, the last count before a trap.
  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [8:0]       class_q, class_d;
  logic [WDW-1:0]   wdogCnt_q, wdogCnt_d;
  logic [CNT_W-1:0] instret_q;
  logic [1:0]       cause_q, cause_d;

  logic [8:0] flags;
  logic       wdogExpired;
  logic       imemReq, dmemReq, dmemWe, irEn, pcEn, regWe, retireC, aluSrc;
  logic [1:0] pcSel, wbSel;

  assign flags = {bus.J, bus.lui, bus.aui, bus.Sb, bus.S,
                  bus.Jr, bus.L, bus.I, bus.R};

  // The watchdog fires on the wait cycle that would be the TIMEOUT-th;
  // an ack in that same cycle is checked first and therefore wins.
  assign wdogExpired = (TIMEOUT != 0) && (wdogCnt_q == WDW'(TIMEOUT - 1));

  // Next-state and control decode; every output defaults to 0 so states
  // only name the controls they actually assert.
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    cause_d   = cause_q;
    imemReq   = 1'b0;
    dmemReq   = 1'b0;
    dmemWe    = 1'b0;
    irEn      = 1'b0;
    pcEn      = 1'b0;
    pcSel     = 2'd0;
    regWe     = 1'b0;
    wbSel     = 2'd0;
    aluSrc    = 1'b0;
    retireC   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imemReq = 1'b1;
        if (bus.imem_ack) begin
          irEn    = 1'b1;
          state_d = ST_DECODE;
        end else if (wdogExpired) begin
          state_d = ST_TRAP;
          cause_d = 2'd2;
        end
      end
      ST_DECODE: begin
        class_d = flags;
        if ($onehot(flags)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = 2'd1;
        end
      end
      ST_EXEC: begin
        aluSrc = class_q[C_I] | class_q[C_L] | class_q[C_S] |
                 class_q[C_JR] | class_q[C_AUI];
        if (class_q[C_SB]) begin
          pcEn    = 1'b1;
          pcSel   = bus.br_taken ? 2'd1 : 2'd0;
          retireC = 1'b1;
          state_d = ST_FETCH;
        end else if (class_q[C_L] || class_q[C_S]) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmemReq = 1'b1;
        dmemWe  = class_q[C_S];
        if (bus.dmem_ack) begin
          if (class_q[C_S]) begin
            pcEn    = 1'b1;
            retireC = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wdogExpired) begin
          state_d = ST_TRAP;
          cause_d = 2'd3;
        end
      end
      ST_WB: begin
        regWe   = 1'b1;
        pcEn    = 1'b1;
        retireC = 1'b1;
        state_d = ST_FETCH;
        if (class_q[C_L])                      wbSel = 2'd1;
        else if (class_q[C_J] || class_q[C_JR]) wbSel = 2'd2;
        else if (class_q[C_LUI])               wbSel = 2'd3;
        if (class_q[C_J])       pcSel = 2'd2;
        else if (class_q[C_JR]) pcSel = 2'd3;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Counts wait cycles while a request stays unanswered; any state change
  // (including entry to FETCH or MEM) restarts it from zero.
  always_comb begin
    wdogCnt_d = '0;
    if ((state_d == state_q) && (state_q == ST_FETCH || state_q == ST_MEM)) begin
      wdogCnt_d = wdogCnt_q + WDW'(1);
    end
  end

  // State, class, watchdog, trap cause and retired count registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      class_q   <= '0;
      wdogCnt_q <= '0;
      instret_q <= '0;
      cause_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wdogCnt_q <= wdogCnt_d;
      cause_q   <= cause_d;
      if (retireC) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  // Requests and strobes are forced low for the whole rst-low cycle so an
  // outstanding access is dropped immediately rather than at the next edge.
  assign bus.imem_req   = imemReq & rst;
  assign bus.dmem_req   = dmemReq & rst;
  assign bus.dmem_we    = dmemWe  & rst;
  assign bus.ir_en      = irEn    & rst;
  assign bus.pc_en      = pcEn    & rst;
  assign bus.reg_we     = regWe   & rst;
  assign bus.retire     = retireC & rst;
  assign bus.pc_sel     = pcSel;
  assign bus.wb_sel     = wbSel;
  assign bus.alu_src    = aluSrc;
  assign bus.instret    = instret_q;
  assign bus.trap       = (state_q == ST_TRAP);
  assign bus.trap_cause = cause_q;

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multi-cycle control FSM for the RV32 core: sequences fetch, decode, execute, memory and writeback around the instruction-type decoder. It latches the one-hot type flags (R, I, L, Jr, S, Sb, aui, lui, J) in DECODE and drives the PC, IR, register-file and ALU enables. It also drives the request/acknowledge handshakes to instruction and data memory, with a wait-state watchdog, trap reporting and a retired-instruction counter.

## Interface
- TIMEOUT, 16: maximum wait cycles on imem/dmem with request high and no ack; 0 disables the watchdog.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- R, I, L, Jr, S, Sb, aui, lui, J  in  1 each  type flags from the type decoder (L = load, I = ALU-immediate, Jr = JALR, Sb = branch)
- br_taken  in  1  branch comparator result, sampled in EXEC
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (store) qualifier, valid with dmem_req
- ir_en  out  1  instruction register load strobe
- pc_en  out  1  PC update strobe
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = JAL target, 3 = JALR target
- reg_we  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = immediate (lui)
- alu_src  out  1  0 = rs2, 1 = immediate
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  retired-instruction count
- trap  out  1  sticky trap indicator
- trap_cause  out  2  0 = none, 1 = illegal type, 2 = imem timeout, 3 = dmem timeout

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state is FETCH.
- FETCH: imem_req=1. On imem_ack: ir_en=1 and go to DECODE. Otherwise stay.
- DECODE: latch the nine flags into a class register.
  - Exactly one flag set: go to EXEC.
  - Zero or more than one set: go to TRAP, cause 1.
- EXEC: alu_src=1 for I, L, S, Jr, aui. Next state by class:
  - R, I, aui, lui, J, Jr: go to WB.
  - L, S: go to MEM.
  - Sb: pc_en=1, pc_sel = br_taken ? 1 : 0, retire=1, go to FETCH.
- MEM: dmem_req=1, dmem_we = (class==S). On dmem_ack:
  - L: go to WB.
  - S: pc_en=1, pc_sel=0, retire=1, go to FETCH.
- WB: reg_we=1, pc_en=1, retire=1, then go to FETCH.
  - wb_sel: L→1, J or Jr→2, lui→3, else 0.
  - pc_sel: J→2, Jr→3, else 0.
- TRAP: all strobes and requests 0, trap=1, trap_cause held. Only reset exits TRAP.
- Watchdog: a counter clears on entry to FETCH or MEM and increments each cycle a request is high without ack.
  - If the counter reaches TIMEOUT-1 and ack is still absent, go to TRAP with cause 2 (FETCH) or 3 (MEM).
  - Ack in the same cycle always wins over timeout.
- instret: increments by 1 on each retire and wraps modulo 2^CNT_W.
- Outputs not named for a state are 0 in that state.
- Acks arriving in states other than FETCH/MEM are ignored.
- Decoder flags are don't-care outside DECODE.

## Timing
- Outputs are decoded combinationally from state and the class register. All requests and strobes are additionally gated with rst, so they are 0 during any cycle in which rst is low.
- Registers updated on a rst-low edge: state=FETCH, class=0, watchdog=0, instret=0, trap=0, trap_cause=0. This applies mid-operation too; an outstanding request drops immediately and the fetch restarts.
- An ack is accepted in the same cycle its request first asserts (zero-wait).
- Latency with zero wait states:
  - R / I / aui / lui / J / Jr: 4 cycles.
  - L: 5 cycles.
  - S: 4 cycles.
  - Sb: 3 cycles.
- Each wait state adds 1 cycle.
- retire coincides with the pc_en cycle. instret shows the new value the following cycle.

## Test plan
- R-type, zero-wait acks, rst released at cycle 0. Required: states FETCH, DECODE, EXEC, WB; reg_we=1, wb_sel=0, pc_sel=0 in cycle 4; instret=1 in cycle 5.
- Load with dmem_ack delayed 2 cycles. Required: 7 cycles; dmem_we=0; WB has wb_sel=1, reg_we=1.
- Branch with br_taken=1, then branch with br_taken=0. Required: EXEC has pc_en=1 with pc_sel=1, then 0; reg_we never asserts; instret=2.
- DECODE with flags R=1 and S=1, then DECODE with no flags. Required: TRAP with trap_cause=1 in each case; no requests while in TRAP; rst low for 1 cycle returns to FETCH with trap=0.
- TIMEOUT=4 and imem_ack held 0. Required: TRAP with cause 2 after 4 cycles of imem_req. Repeat with ack in the 4th cycle: no trap, DECODE next.
- rst low during MEM of a store, with dmem_ack asserted in the same cycle. Required: dmem_req=0 that cycle, no retire, state=FETCH next, instret=0.
